// File: rtl/fsmc_master.sv
// FSMC multiplexed-bus initiator: turns single-word requests into NADV/NWE/NOE/AD timing.
// Every bus pin comes straight from a flop; phase lengths are counted in clk cycles.
module fsmc_master #(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDSET     = 2,
  parameter int unsigned ADDHLD     = 1,
  parameter int unsigned DATASET    = 4,
  parameter int unsigned DATAHLD    = 2,
  parameter int unsigned BUSTURN    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  inout  wire  [ADDR_WIDTH-1:0] AD,
  output logic                  NADV,
  output logic                  NWE,
  output logic                  NOE
);

  localparam int unsigned CntW = 8;

  typedef enum logic [2:0] {
    StIdle, StAddr, StAhold, StWdata, StWhold, StRdata, StTurn
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_done;
  logic            accept;

  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  nadv_d, nwe_d, noe_d, ready_d, busy_d, rsp_valid_d;
  logic                  oe_lo_d, oe_hi_d, oe_lo_q, oe_hi_q;
  logic [ADDR_WIDTH-1:0] ad_d, ad_q;

  function automatic logic [CntW-1:0] phase_load(input state_e s);
    unique case (s)
      StAddr:  return CntW'(ADDSET - 1);
      StAhold: return CntW'(ADDHLD - 1);
      StWdata: return CntW'(DATASET - 1);
      StWhold: return CntW'(DATAHLD - 1);
      StRdata: return CntW'(DATASET - 1);
      StTurn:  return CntW'(BUSTURN - 1);
      default: return '0;
    endcase
  endfunction

  assign phase_done = (cnt_q == '0);
  assign accept     = req_valid && req_ready && (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept)     state_d = StAddr;
      StAddr:  if (phase_done) state_d = StAhold;
      StAhold: if (phase_done) state_d = write_q ? StWdata : StRdata;
      StWdata: if (phase_done) state_d = StWhold;
      StWhold: if (phase_done) state_d = StTurn;
      StRdata: if (phase_done) state_d = StTurn;
      StTurn:  if (phase_done) state_d = StIdle;
      default:                 state_d = StIdle;
    endcase
    // Reload on every state entry, otherwise count down and park at zero.
    if (state_d != state_q) begin
      cnt_d = phase_load(state_d);
    end else if (phase_done) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
    write_d = accept ? req_write : write_q;
    addr_d  = accept ? req_addr  : addr_q;
    wdata_d = accept ? req_wdata : wdata_q;
  end

  // Pin values are decoded from the next state so they land in flops aligned with state_q.
  always_comb begin
    nadv_d      = 1'b1;
    nwe_d       = 1'b1;
    noe_d       = 1'b1;
    oe_lo_d     = 1'b0;
    oe_hi_d     = 1'b0;
    ad_d        = addr_d;
    ready_d     = 1'b0;
    busy_d      = 1'b1;
    rsp_valid_d = (state_q == StRdata) && phase_done;
    unique case (state_d)
      StIdle: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      StAddr: begin
        nadv_d  = 1'b0;
        oe_lo_d = 1'b1;
        oe_hi_d = 1'b1;
      end
      StAhold: begin
        oe_lo_d = 1'b1;
        oe_hi_d = 1'b1;
      end
      StWdata: begin
        nwe_d   = 1'b0;
        oe_lo_d = 1'b1;
        ad_d    = ADDR_WIDTH'(wdata_d);
      end
      StWhold: begin
        oe_lo_d = 1'b1;
        ad_d    = ADDR_WIDTH'(wdata_d);
      end
      StRdata: noe_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      NADV      <= 1'b1;
      NWE       <= 1'b1;
      NOE       <= 1'b1;
      oe_lo_q   <= 1'b0;
      oe_hi_q   <= 1'b0;
      ad_q      <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      NADV      <= nadv_d;
      NWE       <= nwe_d;
      NOE       <= noe_d;
      oe_lo_q   <= oe_lo_d;
      oe_hi_q   <= oe_hi_d;
      ad_q      <= ad_d;
      req_ready <= ready_d;
      busy      <= busy_d;
      rsp_valid <= rsp_valid_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      // Sampled on the edge that also raises NOE.
      if (rsp_valid_d) rsp_rdata <= AD[DATA_WIDTH-1:0];
    end
  end

  assign AD[DATA_WIDTH-1:0] = oe_lo_q ? ad_q[DATA_WIDTH-1:0] : 'z;

  if (ADDR_WIDTH > DATA_WIDTH) begin : g_ad_hi
    assign AD[ADDR_WIDTH-1:DATA_WIDTH] = oe_hi_q ? ad_q[ADDR_WIDTH-1:DATA_WIDTH] : 'z;
  end

endmodule

// File: tb/tb_fsmc_master.sv
// Bench for fsmc_master: directed phase-timing tasks plus a scoreboarded loopback against a
// behavioural FSMC slave model sitting on the AD bus.
module tb_fsmc_master;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int ASET = 2;
  localparam int AHLD = 1;
  localparam int DSET = 4;
  localparam int DHLD = 2;
  localparam int BTURN = 2;
  localparam int WR_LAT = ASET + AHLD + DSET + DHLD + BTURN;
  localparam int RD_LAT = ASET + AHLD + DSET + BTURN;
  localparam logic [AW-1:0] MASK_ALL = {AW{1'b1}};
  localparam logic [AW-1:0] MASK_HI = {{(AW-DW){1'b1}}, {DW{1'b0}}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, busy, nadv, nwe, noe;
  logic [DW-1:0] rsp_rdata;
  wire  [AW-1:0] ad;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  bit in_rst = 1'b0;

  logic [AW-1:0]    bus_addr = '0;
  logic [DW-1:0]    rd_drive = '0;
  logic [DW-1:0]    slave_mem [logic [AW-1:0]];
  logic [DW-1:0]    ref_mem [logic [AW-1:0]];
  logic [DW-1:0]    rd_q [$];
  logic [AW+DW-1:0] wr_q [$];

  always #5 clk = ~clk;

  // Slave model answers reads while NOE is low.
  assign ad[DW-1:0] = noe ? 'z : rd_drive;

  fsmc_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDSET(ASET), .ADDHLD(AHLD),
    .DATASET(DSET), .DATAHLD(DHLD), .BUSTURN(BTURN)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .AD(ad), .NADV(nadv), .NWE(nwe), .NOE(noe)
  );

  function automatic bit released(input logic [AW-1:0] v, input logic [AW-1:0] mask);
    for (int i = 0; i < AW; i++) begin
      if (mask[i] && v[i] !== 1'b0 && v[i] !== 1'bz) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Phase code for cycle k after the accept edge: 0 addr, 1 ahold, 2 data, 3 whold, 4 turn, 5 idle.
  function automatic int phase_of(input int k, input bit wr);
    int t;
    t = k;
    if (t <= ASET) return 0;
    t -= ASET;
    if (t <= AHLD) return 1;
    t -= AHLD;
    if (t <= DSET) return 2;
    t -= DSET;
    if (wr) begin
      if (t <= DHLD) return 3;
      t -= DHLD;
    end
    if (t <= BTURN) return 4;
    return 5;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    in_rst = rst;
  end

  initial begin : monitor
    int nadv_run, nwe_run, noe_run;
    logic prev_nadv, prev_nwe, prev_noe;
    logic [DW-1:0] wr_seen;
    logic [AW+DW-1:0] wexp;
    logic [DW-1:0] rexp;
    nadv_run = 0; nwe_run = 0; noe_run = 0;
    prev_nadv = 1'b1; prev_nwe = 1'b1; prev_noe = 1'b1;
    wr_seen = '0;
    forever begin
      @(negedge clk);
      if (in_rst) begin
        nadv_run = 0; nwe_run = 0; noe_run = 0;
      end else begin
        checks++;
        if ({!nwe && !noe, !nadv && (!nwe || !noe)} !== 2'b00)
          $display("FAIL strobe_excl: nadv=%b nwe=%b noe=%b required no overlap", nadv, nwe, noe);
        else passes++;
        if (!nadv) begin
          nadv_run++;
          bus_addr = ad;
          rd_drive = slave_mem.exists(ad) ? slave_mem[ad] : '0;
        end else if (!prev_nadv) begin
          checks++;
          if (nadv_run !== ASET) $display("FAIL nadv_len: got %0d required %0d", nadv_run, ASET);
          else passes++;
          nadv_run = 0;
        end
        if (!nwe) begin
          nwe_run++;
          wr_seen = ad[DW-1:0];
        end else if (!prev_nwe) begin
          checks++;
          if (nwe_run !== DSET) $display("FAIL nwe_len: got %0d required %0d", nwe_run, DSET);
          else passes++;
          nwe_run = 0;
          slave_mem[bus_addr] = wr_seen;
          checks++;
          if (wr_q.size() == 0) begin
            $display("FAIL bus_write: got %h/%h required none", bus_addr, wr_seen);
          end else begin
            wexp = wr_q.pop_front();
            if ({bus_addr, wr_seen} !== wexp)
              $display("FAIL bus_write: got %h/%h required %h/%h", bus_addr, wr_seen,
                       wexp[AW+DW-1:DW], wexp[DW-1:0]);
            else passes++;
          end
        end
        if (!noe) begin
          noe_run++;
        end else if (!prev_noe) begin
          checks++;
          if (noe_run !== DSET) $display("FAIL noe_len: got %0d required %0d", noe_run, DSET);
          else passes++;
          noe_run = 0;
        end
        if (rsp_valid) begin
          checks++;
          if (rd_q.size() == 0) begin
            $display("FAIL rsp_unexpected: got rsp_valid=1 rdata=%h required none", rsp_rdata);
          end else begin
            rexp = rd_q.pop_front();
            if (rsp_rdata !== rexp) $display("FAIL rsp_rdata: got %h required %h", rsp_rdata, rexp);
            else passes++;
          end
        end
      end
      prev_nadv = nadv;
      prev_nwe  = nwe;
      prev_noe  = noe;
    end
  end

  // Called at a negedge; returns at the negedge just after the accept edge (first ADDR cycle).
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit track, input bit hold);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      $display("FAIL accept_timeout: got req_ready=%b required 1", req_ready);
    end
    if (track) begin
      if (wr) begin
        wr_q.push_back({a, d});
        ref_mem[a] = d;
      end else begin
        rd_q.push_back(ref_mem.exists(a) ? ref_mem[a] : '0);
      end
    end
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({nadv, nwe, noe, req_ready, rsp_valid, busy} !== 6'b111000)
      $display("FAIL reset_pins: got %b required 111000",
               {nadv, nwe, noe, req_ready, rsp_valid, busy});
    else passes++;
    checks++;
    if (rsp_rdata !== '0) $display("FAIL reset_rdata: got %h required 0", rsp_rdata);
    else passes++;
    checks++;
    if (released(ad, MASK_ALL) !== 1'b1) $display("FAIL reset_ad: got %h required Z", ad);
    else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, busy} !== 2'b10) $display("FAIL reset_release: got %b required 10",
                                               {req_ready, busy});
    else passes++;
  endtask

  task automatic test_write();
    logic [AW-1:0] a = 18'h10034;
    logic [DW-1:0] d = 16'hBEEF;
    int ph;
    logic [4:0] exp_pins;
    issue(1'b1, a, d, 1'b1, 1'b0);
    for (int k = 1; k <= WR_LAT + 1; k++) begin
      ph = phase_of(k, 1'b1);
      exp_pins = {ph != 0, ph != 2, 1'b1, ph != 5, ph == 5};
      checks++;
      if ({nadv, nwe, noe, busy, req_ready} !== exp_pins)
        $display("FAIL wr_pins k=%0d: got %b required %b", k, {nadv, nwe, noe, busy, req_ready},
                 exp_pins);
      else passes++;
      checks++;
      if (ph <= 1) begin
        if (ad !== a) $display("FAIL wr_addr k=%0d: got %h required %h", k, ad, a);
        else passes++;
      end else if (ph <= 3) begin
        if ({ad[DW-1:0], released(ad, MASK_HI)} !== {d, 1'b1})
          $display("FAIL wr_data k=%0d: got %h required %h with upper Z", k, ad, d);
        else passes++;
      end else begin
        if (released(ad, MASK_ALL) !== 1'b1) $display("FAIL wr_release k=%0d: got %h required Z",
                                                       k, ad);
        else passes++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_read();
    logic [AW-1:0] a = 18'h00010;
    int ph;
    logic [5:0] exp_pins;
    slave_mem[a] = 16'h1234;
    ref_mem[a]   = 16'h1234;
    issue(1'b0, a, '0, 1'b1, 1'b0);
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      ph = phase_of(k, 1'b0);
      exp_pins = {ph != 0, 1'b1, ph != 2, ph != 5, ph == 5, k == ASET + AHLD + DSET + 1};
      checks++;
      if ({nadv, nwe, noe, busy, req_ready, rsp_valid} !== exp_pins)
        $display("FAIL rd_pins k=%0d: got %b required %b", k,
                 {nadv, nwe, noe, busy, req_ready, rsp_valid}, exp_pins);
      else passes++;
      checks++;
      if (ph <= 1) begin
        if (ad !== a) $display("FAIL rd_addr k=%0d: got %h required %h", k, ad, a);
        else passes++;
      end else if (ph == 2) begin
        if ({ad[DW-1:0], released(ad, MASK_HI)} !== {16'h1234, 1'b1})
          $display("FAIL rd_bus k=%0d: got %h required 1234 from slave only", k, ad);
        else passes++;
      end else begin
        if (released(ad, MASK_ALL) !== 1'b1) $display("FAIL rd_release k=%0d: got %h required Z",
                                                       k, ad);
        else passes++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, t2;
    issue(1'b1, 18'h20A5C, 16'h1357, 1'b1, 1'b1);
    t0 = cyc;
    issue(1'b0, 18'h20A5C, '0, 1'b1, 1'b1);
    t1 = cyc;
    issue(1'b1, 18'h00777, 16'hFACE, 1'b1, 1'b0);
    t2 = cyc;
    checks++;
    if (t1 - t0 !== WR_LAT + 1) $display("FAIL b2b_wr_gap: got %0d required %0d", t1 - t0,
                                          WR_LAT + 1);
    else passes++;
    checks++;
    if (t2 - t1 !== RD_LAT + 1) $display("FAIL b2b_rd_gap: got %0d required %0d", t2 - t1,
                                          RD_LAT + 1);
    else passes++;
    repeat (WR_LAT + 2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 18'h12345, 16'hDEAD, 1'b0, 1'b0);
    repeat (ASET + AHLD + 1) @(negedge clk);
    checks++;
    if (nwe !== 1'b0) $display("FAIL rstmid_setup: got nwe=%b required 0", nwe);
    else passes++;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({nadv, nwe, noe, busy, req_ready, rsp_valid} !== 6'b111000)
      $display("FAIL rstmid_pins: got %b required 111000",
               {nadv, nwe, noe, busy, req_ready, rsp_valid});
    else passes++;
    checks++;
    if (released(ad, MASK_ALL) !== 1'b1) $display("FAIL rstmid_ad: got %h required Z", ad);
    else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) $display("FAIL rstmid_ready: got %b required 1", req_ready);
    else passes++;
    checks++;
    if (slave_mem.exists(18'h12345) !== 0) $display("FAIL rstmid_dropped: got write required none");
    else passes++;
    issue(1'b0, 18'h20A5C, '0, 1'b1, 1'b0);
    repeat (RD_LAT + 2) @(negedge clk);
  endtask

  task automatic test_loopback();
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < 300; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = {2'($urandom_range(0, 3)), 12'h000, 4'($urandom_range(0, 15))};
      d  = 16'($urandom);
      issue(wr, a, d, 1'b1, 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 15)) @(negedge clk);
      end
    end
    req_valid = 1'b0;
    repeat (WR_LAT + 4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    checks++;
    if (rd_q.size() + wr_q.size() !== 0)
      $display("FAIL drain: got %0d reads %0d writes outstanding required 0", rd_q.size(),
               wr_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
